crash_arbiter: RTL and testbench

Pixel-stream collision arbiter between the sprite layers and the enemy/player state machines. Each `clk_vga` cycle it samples the per-pixel alpha of the player plane, the bullet layer and every enemy layer. It turns overlaps into single-cycle crash pulses, rate-limited to at most one hit per layer per holdoff window. It also tracks player life and asserts game over. Its outputs feed the enemy blocks' `crash_enemy_bullet_i` / `crash_me_enemy_i`, the bullet block's kill input and the top-level game FSM.

---
 rtl/crash_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_crash_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crash_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : crash_arbiter
//  Purpose  : Pixel-stream collision arbiter. On every clk_vga cycle it samples
//             the per-pixel alpha of the player plane, the bullet layer and
//             each enemy layer. Overlaps become one-cycle crash pulses, and
//             each layer (and the player) is limited to one hit per holdoff
//             window, counted in frames. It also tracks player life and
//             raises a sticky game-over.
//  Ports    : clk_vga, rst (async, active-high)
//             en_i, v_sync_i, pix_vali_i         - game/frame/pixel qualifiers
//             me_alpha_i, bullet_alpha_i,
//             enemy_alpha_i[N_ENEMY]             - per-pixel opacities
//             crash_enemy_bullet_o[N_ENEMY]      - bullet hit layer k (pulse)
//             crash_me_enemy_o[N_ENEMY]          - player hit layer k (pulse)
//             crash_bullet_o                     - kill the bullet (pulse)
//             me_hit_o                           - player lost a life (pulse)
//             me_life_o                          - remaining lives
//             game_over_o                        - sticky game-over level
//  Revision : 1.0 - initial release
// ============================================================================
module crash_arbiter #(
  parameter int N_ENEMY              = 3,
  parameter int ENEMY_HOLDOFF_FRAMES = 1,
  parameter int ME_HOLDOFF_FRAMES    = 60,
  parameter int ME_LIFE              = 3,
  parameter int ME_LIFE_BIT_LEN      = 2,
  parameter int HOLD_BIT_LEN         = 6
) (
  input  logic                       clk_vga,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic                       v_sync_i,
  input  logic                       pix_vali_i,
  input  logic                       me_alpha_i,
  input  logic                       bullet_alpha_i,
  input  logic [N_ENEMY-1:0]         enemy_alpha_i,
  output logic [N_ENEMY-1:0]         crash_enemy_bullet_o,
  output logic [N_ENEMY-1:0]         crash_me_enemy_o,
  output logic                       crash_bullet_o,
  output logic                       me_hit_o,
  output logic [ME_LIFE_BIT_LEN-1:0] me_life_o,
  output logic                       game_over_o
);

  // Layer FSM: ARMED / HOLD. The player FSM reuses the encoding (INVULN = HOLD).
  localparam logic [0:0] ST_ARMED  = 1'b0;
  localparam logic [0:0] ST_HOLD   = 1'b1;
  localparam logic [0:0] ST_INVULN = 1'b1;

  localparam logic [HOLD_BIT_LEN-1:0]    C_ENEMY_HOLD = HOLD_BIT_LEN'(ENEMY_HOLDOFF_FRAMES);
  localparam logic [HOLD_BIT_LEN-1:0]    C_ME_HOLD    = HOLD_BIT_LEN'(ME_HOLDOFF_FRAMES);
  localparam logic [HOLD_BIT_LEN-1:0]    C_HOLD_ONE   = HOLD_BIT_LEN'(1);
  localparam logic [ME_LIFE_BIT_LEN-1:0] C_ME_LIFE    = ME_LIFE_BIT_LEN'(ME_LIFE);
  localparam logic [ME_LIFE_BIT_LEN-1:0] C_LIFE_ONE   = ME_LIFE_BIT_LEN'(1);
  localparam logic [ME_LIFE_BIT_LEN-1:0] C_LIFE_ZERO  = '0;

  // --------------------------------------------------------------------------
  // Frame-start edge detector. r_sync_primed blocks the first cycle after
  // reset so a v_sync already high at release is not taken as a new frame.
  // --------------------------------------------------------------------------
  logic r_v_sync_q;
  logic r_sync_primed;
  logic w_frame_start;

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      r_v_sync_q    <= 1'b0;
      r_sync_primed <= 1'b0;
    end else begin
      r_v_sync_q    <= v_sync_i;
      r_sync_primed <= 1'b1;
    end
  end

  assign w_frame_start = v_sync_i & ~r_v_sync_q & r_sync_primed;

  // --------------------------------------------------------------------------
  // Output / life registers
  // --------------------------------------------------------------------------
  logic [N_ENEMY-1:0]         r_crash_enemy_bullet;
  logic [N_ENEMY-1:0]         r_crash_me_enemy;
  logic                       r_crash_bullet;
  logic                       r_me_hit;
  logic [ME_LIFE_BIT_LEN-1:0] r_me_life;
  logic                       r_game_over;

  logic                       w_qual;
  logic [N_ENEMY-1:0]         w_crash_me;
  logic [N_ENEMY-1:0]         w_crash_bul;
  logic                       w_me_hit;

  assign w_qual = en_i & pix_vali_i & ~r_game_over;

  // --------------------------------------------------------------------------
  // Player FSM. The player counts as armed already on the frame edge that
  // expires its holdoff, so that pixel can register a new hit.
  // --------------------------------------------------------------------------
  logic [0:0]              r_me_state;
  logic [HOLD_BIT_LEN-1:0] r_me_hold;
  logic                    w_me_armed;

  assign w_me_armed = (r_me_state == ST_ARMED) |
                      (w_frame_start & (r_me_hold == C_HOLD_ONE));

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      r_me_state <= ST_ARMED;
      r_me_hold  <= '0;
    end else if (!en_i) begin
      r_me_state <= ST_ARMED;
      r_me_hold  <= '0;
    end else if (w_me_hit) begin
      // A hit on a frame-start cycle reloads; that edge is not counted.
      r_me_state <= ST_INVULN;
      r_me_hold  <= C_ME_HOLD;
    end else if ((r_me_state == ST_INVULN) && w_frame_start) begin
      r_me_hold <= r_me_hold - C_HOLD_ONE;
      if (r_me_hold == C_HOLD_ONE) begin
        r_me_state <= ST_ARMED;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-enemy-layer FSMs and crash decode
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < N_ENEMY; k++) begin : g_layer
    logic [0:0]              r_state;
    logic [HOLD_BIT_LEN-1:0] r_hold;
    logic                    w_armed;

    assign w_armed = (r_state == ST_ARMED) |
                     (w_frame_start & (r_hold == C_HOLD_ONE));

    // Player crash wins over bullet crash on the same layer and pixel.
    assign w_crash_me[k]  = w_qual & me_alpha_i & enemy_alpha_i[k] &
                            w_armed & w_me_armed;
    assign w_crash_bul[k] = w_qual & bullet_alpha_i & enemy_alpha_i[k] &
                            w_armed & ~w_crash_me[k];

    always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
        r_state <= ST_ARMED;
        r_hold  <= '0;
      end else if (!en_i) begin
        r_state <= ST_ARMED;
        r_hold  <= '0;
      end else if (w_crash_me[k] | w_crash_bul[k]) begin
        r_state <= ST_HOLD;
        r_hold  <= C_ENEMY_HOLD;
      end else if ((r_state == ST_HOLD) && w_frame_start) begin
        r_hold <= r_hold - C_HOLD_ONE;
        if (r_hold == C_HOLD_ONE) begin
          r_state <= ST_ARMED;
        end
      end
    end
  end

  assign w_me_hit = |w_crash_me;

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      r_crash_enemy_bullet <= '0;
      r_crash_me_enemy     <= '0;
      r_crash_bullet       <= 1'b0;
      r_me_hit             <= 1'b0;
      r_me_life            <= C_ME_LIFE;
      r_game_over          <= 1'b0;
    end else begin
      r_crash_enemy_bullet <= w_crash_bul;
      r_crash_me_enemy     <= w_crash_me;
      r_crash_bullet       <= |w_crash_bul;
      r_me_hit             <= w_me_hit;
      if (w_me_hit) begin
        if (r_me_life != C_LIFE_ZERO) begin
          r_me_life <= r_me_life - C_LIFE_ONE;
        end
        // Game over lands together with the hit that takes the last life.
        if (r_me_life <= C_LIFE_ONE) begin
          r_game_over <= 1'b1;
        end
      end
    end
  end

  assign crash_enemy_bullet_o = r_crash_enemy_bullet;
  assign crash_me_enemy_o     = r_crash_me_enemy;
  assign crash_bullet_o       = r_crash_bullet;
  assign me_hit_o             = r_me_hit;
  assign me_life_o            = r_me_life;
  assign game_over_o          = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_crash_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_crash_arbiter
//  Purpose  : Self-checking bench for crash_arbiter. Directed scenarios plus
//             randomized episodes, all compared against a frame-count model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_crash_arbiter;

  localparam int NE   = 3;
  localparam int EH   = 1;
  localparam int MH   = 2;
  localparam int LIFE = 3;

  logic          clk_vga = 1'b0;
  logic          rst = 1'b1;
  logic          en_i = 1'b0;
  logic          v_sync_i = 1'b0;
  logic          pix_vali_i = 1'b0;
  logic          me_alpha_i = 1'b0;
  logic          bullet_alpha_i = 1'b0;
  logic [NE-1:0] enemy_alpha_i = '0;
  wire  [NE-1:0] crash_enemy_bullet_o;
  wire  [NE-1:0] crash_me_enemy_o;
  wire           crash_bullet_o;
  wire           me_hit_o;
  wire  [1:0]    me_life_o;
  wire           game_over_o;

  crash_arbiter #(
    .N_ENEMY              (NE),
    .ENEMY_HOLDOFF_FRAMES (EH),
    .ME_HOLDOFF_FRAMES    (MH),
    .ME_LIFE              (LIFE),
    .ME_LIFE_BIT_LEN      (2),
    .HOLD_BIT_LEN         (6)
  ) u_dut (
    .clk_vga              (clk_vga),
    .rst                  (rst),
    .en_i                 (en_i),
    .v_sync_i             (v_sync_i),
    .pix_vali_i           (pix_vali_i),
    .me_alpha_i           (me_alpha_i),
    .bullet_alpha_i       (bullet_alpha_i),
    .enemy_alpha_i        (enemy_alpha_i),
    .crash_enemy_bullet_o (crash_enemy_bullet_o),
    .crash_me_enemy_o     (crash_me_enemy_o),
    .crash_bullet_o       (crash_bullet_o),
    .me_hit_o             (me_hit_o),
    .me_life_o            (me_life_o),
    .game_over_o          (game_over_o)
  );

  always #5 clk_vga = ~clk_vga;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: frames left before each layer / the player may be hit.
  int            m_rem [NE];
  int            m_me_rem;
  int            m_life;
  bit            m_go;
  bit            m_vs_prev;
  bit            m_vs_live;
  logic [NE-1:0] e_eb;
  logic [NE-1:0] e_me;
  bit            e_cb;
  bit            e_hit;
  int            n_cb_seen;
  int            n_hit_seen;

  task automatic model_reset();
    for (int k = 0; k < NE; k++) m_rem[k] = 0;
    m_me_rem  = 0;
    m_life    = LIFE;
    m_go      = 0;
    m_vs_prev = 0;
    m_vs_live = 0;
    e_eb = '0; e_me = '0; e_cb = 0; e_hit = 0;
  endtask

  // Effect of the next rising clock edge given the inputs currently driven.
  task automatic model_step();
    bit fs;
    bit q;
    fs = v_sync_i & ~m_vs_prev & m_vs_live;
    m_vs_prev = v_sync_i;
    m_vs_live = 1;
    e_eb = '0; e_me = '0; e_cb = 0; e_hit = 0;
    if (!en_i) begin
      for (int k = 0; k < NE; k++) m_rem[k] = 0;
      m_me_rem = 0;
      return;
    end
    if (fs) begin
      for (int k = 0; k < NE; k++) if (m_rem[k] > 0) m_rem[k]--;
      if (m_me_rem > 0) m_me_rem--;
    end
    q = pix_vali_i & ~m_go;
    for (int k = 0; k < NE; k++) begin
      if (q && enemy_alpha_i[k] && m_rem[k] == 0) begin
        if (me_alpha_i && m_me_rem == 0) e_me[k] = 1'b1;
        else if (bullet_alpha_i)         e_eb[k] = 1'b1;
      end
    end
    e_hit = |e_me;
    e_cb  = |e_eb;
    if (e_hit) begin
      if (m_life > 0) m_life--;
      if (m_life == 0) m_go = 1;
      m_me_rem = MH;
    end
    for (int k = 0; k < NE; k++) if (e_me[k] || e_eb[k]) m_rem[k] = EH;
  endtask

  task automatic compare();
    chk_val("crash_enemy_bullet", crash_enemy_bullet_o, e_eb);
    chk_val("crash_me_enemy", crash_me_enemy_o, e_me);
    chk_val("crash_bullet", crash_bullet_o, e_cb);
    chk_val("me_hit", me_hit_o, e_hit);
    chk_val("me_life", me_life_o, m_life);
    chk_val("game_over", game_over_o, m_go);
    n_cb_seen  += int'(crash_bullet_o);
    n_hit_seen += int'(me_hit_o);
  endtask

  task automatic cycle(input bit a_en, input bit a_pix, input bit a_me, input bit a_b,
                       input logic [NE-1:0] a_enemy, input bit a_vs);
    compare();
    en_i           = a_en;
    pix_vali_i     = a_pix;
    me_alpha_i     = a_me;
    bullet_alpha_i = a_b;
    enemy_alpha_i  = a_enemy;
    v_sync_i       = a_vs;
    model_step();
  endtask

  task automatic drive(input bit a_en, input bit a_pix, input bit a_me, input bit a_b,
                       input logic [NE-1:0] a_enemy, input bit a_vs);
    @(negedge clk_vga);
    cycle(a_en, a_pix, a_me, a_b, a_enemy, a_vs);
  endtask

  task automatic idle();
    drive(1, 1, 0, 0, '0, 0);
  endtask

  task automatic frame_edge();
    drive(1, 0, 0, 0, '0, 1);
    drive(1, 0, 0, 0, '0, 1);
    drive(1, 0, 0, 0, '0, 0);
  endtask

  // Asynchronous reset away from the clock edge, with immediate value checks.
  task automatic do_reset(input bit vs_at_release);
    @(negedge clk_vga);
    compare();
    #2 rst = 1'b1;
    #1;
    chk_val("rst_life", me_life_o, LIFE);
    chk_val("rst_game_over", game_over_o, 0);
    chk_val("rst_pulses", {crash_enemy_bullet_o, crash_me_enemy_o, crash_bullet_o, me_hit_o}, 0);
    model_reset();
    en_i = 0; pix_vali_i = 0; me_alpha_i = 0; bullet_alpha_i = 0; enemy_alpha_i = '0;
    v_sync_i = vs_at_release;
    repeat (2) @(negedge clk_vga);
    rst = 1'b0;
    cycle(1, 0, 0, 0, '0, vs_at_release);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pos;
    int flen;
    model_reset();
    repeat (2) @(negedge clk_vga);
    rst = 1'b0;
    cycle(1, 0, 0, 0, '0, 0);

    // Single bullet hit on layer 1, five consecutive overlapping pixels.
    frame_edge();
    n_cb_seen = 0;
    repeat (5) drive(1, 1, 0, 1, 3'b010, 0);
    repeat (2) idle();
    chk_val("s1_one_pulse", n_cb_seen, 1);
    repeat (3) drive(1, 1, 0, 1, 3'b010, 0);
    repeat (2) idle();
    chk_val("s1_no_repeat", n_cb_seen, 1);
    frame_edge();
    drive(1, 1, 0, 1, 3'b010, 0);
    idle();
    chk_val("s1_next_frame", n_cb_seen, 2);

    // Precedence: player, bullet and layer 0 on the same pixel.
    drive(1, 1, 1, 1, 3'b001, 0);
    idle();
    chk_val("prec_me", crash_me_enemy_o, 3'b001);
    chk_val("prec_eb", crash_enemy_bullet_o, 0);
    chk_val("prec_cb", crash_bullet_o, 0);
    chk_val("prec_life", me_life_o, 2);

    // Two layers hit by the bullet on one pixel.
    frame_edge();
    drive(1, 1, 0, 1, 3'b101, 0);
    idle();
    chk_val("multi_eb", crash_enemy_bullet_o, 3'b101);
    chk_val("multi_cb", crash_bullet_o, 1);

    // Invulnerability (2 frames) down to game over.
    do_reset(0);
    n_hit_seen = 0;
    for (int f = 0; f < 7; f++) begin
      frame_edge();
      drive(1, 1, 1, 0, 3'b100, 0);
      idle();
      chk_val($sformatf("inv_hit_f%0d", f), me_hit_o, (f % 2 == 0 && f <= 4) ? 1 : 0);
    end
    chk_val("inv_hits", n_hit_seen, 3);
    chk_val("inv_life", me_life_o, 0);
    chk_val("inv_over", game_over_o, 1);

    // Gating by pix_vali_i and en_i, and re-arm on en_i drop.
    do_reset(0);
    n_cb_seen = 0; n_hit_seen = 0;
    drive(1, 0, 1, 1, 3'b111, 0);
    drive(0, 1, 1, 1, 3'b111, 0);
    idle();
    chk_val("gate_cb", n_cb_seen, 0);
    chk_val("gate_hit", n_hit_seen, 0);
    drive(1, 1, 0, 1, 3'b010, 0);
    drive(0, 1, 0, 0, 3'b000, 0);
    drive(1, 1, 0, 1, 3'b010, 0);
    idle();
    chk_val("rearm_eb", crash_enemy_bullet_o, 3'b010);

    // Reset mid-holdoff with one life left.
    drive(1, 1, 1, 0, 3'b001, 0);
    frame_edge();
    frame_edge();
    drive(1, 1, 1, 0, 3'b010, 0);
    repeat (2) idle();
    chk_val("pre_rst_life", me_life_o, 1);
    do_reset(1);

    // Randomized episodes.
    for (int ep = 0; ep < 12; ep++) begin
      do_reset(1'($urandom % 2));
      pos  = 0;
      flen = 6 + int'($urandom % 15);
      for (int c = 0; c < 300; c++) begin
        drive($urandom % 16 != 0,
              $urandom % 4 != 0,
              ($urandom % 8) < (ep % 3),
              $urandom % 3 == 0,
              NE'($urandom),
              pos < 2);
        pos++;
        if (pos >= flen) begin
          pos  = 0;
          flen = 6 + int'($urandom % 15);
        end
      end
    end

    @(negedge clk_vga);
    compare();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
